data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit words; power of two, 4..4096.
REQ-002 Parameter WAIT_CYCLES, default 2, extra wait cycles per access; range 0..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  requester presents an access.
REQ-006 req_ready  output  1  responder can accept an access this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 rsp_valid  output  1  one-cycle response strobe.
REQ-011 rsp_rdata  output  32  load data, valid with rsp_valid.
REQ-012 rsp_err  output  1  access error, valid with rsp_valid.

Function
REQ-013 States: IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-014 Accept occurs when req_valid && req_ready at a rising edge; the responder latches write, addr and wdata.
- After accept, the next state is WAIT if WAIT_CYCLES>0, else RESP.
REQ-015 WAIT: the wait counter loads WAIT_CYCLES-1 on accept and decrements each cycle; when the counter is 0, the next state is RESP.
REQ-016 rsp_valid SHALL be 1 for exactly one cycle, in RESP, and SHALL assert WAIT_CYCLES+1 cycles after the accept edge; RESP always returns to IDLE.
- No response back-pressure: the requester must take the response in that cycle.
REQ-017 Word index = addr[$clog2(DEPTH)+1:2]; higher address bits are ignored (aliasing/wrap-around).
REQ-018 Store commits to the array on the WAIT/IDLE->RESP transition edge; in RESP, rsp_rdata = 0.
REQ-019 Load: in RESP, rsp_rdata = the array word at the latched index, including any store whose response has already completed.
REQ-020 Outside RESP: rsp_rdata = 0 and rsp_err = 0.
REQ-021 req_valid during WAIT or RESP SHALL be ignored (not accepted, not queued).
- The earliest back-to-back accept is the IDLE cycle following RESP.
- Throughput: one access per WAIT_CYCLES+2 cycles.

Reset
REQ-022 On reset: state = IDLE, counter = 0, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-023 Reset takes priority over accept in the same cycle.
- Reset mid-operation aborts the access; a store not yet committed SHALL NOT be written.
REQ-024 Array contents are not cleared by reset.

Configuration
REQ-025 Macro ALIGN_CHECK_EN defined:
- addr[1:0] != 0 produces rsp_err = 1 and rsp_rdata = 0.
- No array write occurs.
- Same latency as a normal access.
REQ-026 ALIGN_CHECK_EN undefined:
- addr[1:0] are ignored.
- rsp_err is constant 0.

Structure
REQ-027 Shared package mem_pkg SHALL hold the state enum (IDLE/WAIT/RESP), the WORD_W=32 constant and the default DEPTH/WAIT_CYCLES constants.
REQ-028 One sub-module, dmem_array:
- Single-port synchronous-write array.
- Combinational read by index.
- Ports: clk, we, idx, wdata, rdata.

Verification
REQ-029 Store 0xDEADBEEF at 0x10, then load 0x10 -> rsp_rdata = 0xDEADBEEF; each rsp_valid arrives 3 cycles after its accept (WAIT_CYCLES=2).
REQ-030 WAIT_CYCLES=0, back-to-back loads with req_valid held high:
- rsp_valid arrives 1 cycle after each accept.
- Accepts occur every 2 cycles.
- req_ready = 0 in RESP.
REQ-031 DEPTH=256: store 0x12345678 at 0x400, load 0x000 -> 0x12345678 (wrap-around).
REQ-032 Assert reset in the first WAIT cycle of a store of 0xAAAA5555 to 0x20:
- Outputs return to reset values.
- A later load of 0x20 returns the prior value.
REQ-033 ALIGN_CHECK_EN defined, store 0x1 to 0x22:
- rsp_err = 1 after 3 cycles.
- A later load of 0x20 shows unchanged data.
- With the macro undefined, rsp_err = 0 and the word at 0x20 becomes 0x1.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data memory responder.
// Contents:
//   state_t              responder FSM states (IDLE / WAIT / RESP)
//   WORD_W               data word width in bits
//   DEFAULT_DEPTH        default number of words in the array
//   DEFAULT_WAIT_CYCLES  default extra wait cycles per access
package mem_pkg;

    localparam int WORD_W              = 32;
    localparam int DEFAULT_DEPTH       = 256;
    localparam int DEFAULT_WAIT_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage for the data memory responder.
// The array has a single port. Writes are synchronous and reads are
// combinational, so the responder can sample the addressed word on the
// same edge that it enters its response state.
// Ports:
//   clk    in   clock
//   we     in   write enable; writes wdata to word idx on the rising edge
//   idx    in   word index
//   wdata  in   write data
//   rdata  out  word at idx (combinational)
module dmem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [WORD_W-1:0]        wdata,
    output logic [WORD_W-1:0]        rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder. It accepts one load or store at a time.
// After an access is accepted, the responder waits WAIT_CYCLES cycles.
// It then gives a single-cycle response, and then returns to IDLE.
// Higher address bits alias onto the word array.
// The response outputs are registered: they are loaded on the edge that
// enters RESP, which is also the edge on which a store commits.
// Optional feature: define ALIGN_CHECK_EN to flag misaligned addresses
// (addr[1:0] != 0). A misaligned access responds with rsp_err = 1 and
// rsp_rdata = 0, and a misaligned store is not written.
// Without the macro, addr[1:0] are ignored and rsp_err stays 0.
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset
//   req_valid  in   access request
//   req_ready  out  high only in IDLE
//   req_write  in   1 = store, 0 = load
//   req_addr   in   byte address
//   req_wdata  in   store data
//   rsp_valid  out  one-cycle response strobe
//   rsp_rdata  out  load data (0 for stores, errors and outside RESP)
//   rsp_err    out  access error, valid with rsp_valid
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = 4;

    state_t              state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                req_ready_reg;
    logic                rsp_valid_reg;
    logic [WORD_W-1:0]   rsp_rdata_reg;
    logic                rsp_err_reg;

    // Access captured at accept time.
    logic                write_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic [WORD_W-1:0]   wdata_reg;
    logic                misalign_reg;

    logic                req_misalign;
    logic                go_resp;
    logic                cur_write;
    logic [IDX_W-1:0]    cur_idx;
    logic [WORD_W-1:0]   cur_wdata;
    logic                cur_misalign;
    logic                mem_we;
    logic [WORD_W-1:0]   mem_rdata;

`ifdef ALIGN_CHECK_EN
    assign req_misalign = (req_addr[1:0] != 2'b00);
`else
    assign req_misalign = 1'b0;
`endif

    // Address bits outside the word index alias away by design.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, req_addr[31:IDX_W+2], req_addr[1:0]};

    // With zero wait cycles, the accept edge is also the commit/response
    // edge. The array is then driven straight from the request inputs
    // instead of the latched copy.
    assign go_resp = ((state_reg == IDLE) && req_valid && (WAIT_CYCLES == 0))
                   || ((state_reg == WAIT) && (cnt_reg == '0));

    always_comb begin
        cur_write    = write_reg;
        cur_idx      = idx_reg;
        cur_wdata    = wdata_reg;
        cur_misalign = misalign_reg;
        if (state_reg == IDLE) begin
            cur_write    = req_write;
            cur_idx      = req_addr[IDX_W+1:2];
            cur_wdata    = req_wdata;
            cur_misalign = req_misalign;
        end
    end

    // Reset on the commit edge aborts the store.
    assign mem_we = go_resp && cur_write && !cur_misalign && !reset;

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .idx   (cur_idx),
        .wdata (cur_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        write_reg     <= req_write;
                        idx_reg       <= req_addr[IDX_W+1:2];
                        wdata_reg     <= req_wdata;
                        misalign_reg  <= req_misalign;
                        req_ready_reg <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state_reg <= RESP;
                        end else begin
                            state_reg <= WAIT;
                            cnt_reg   <= CNT_W'(WAIT_CYCLES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_reg == '0) begin
                        state_reg <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                RESP: begin
                    state_reg     <= IDLE;
                    req_ready_reg <= 1'b1;
                end
                default: begin
                    state_reg     <= IDLE;
                    req_ready_reg <= 1'b1;
                end
            endcase

            if (go_resp) begin
                rsp_valid_reg <= 1'b1;
                rsp_err_reg   <= cur_misalign;
                rsp_rdata_reg <= (cur_write || cur_misalign) ? '0 : mem_rdata;
            end
        end
    end

    assign req_ready = req_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder.
// Two instances are used: u_dut has the default configuration, and u_dut0
// has WAIT_CYCLES=0 and DEPTH=16.
// The expected alignment-check behaviour follows ALIGN_CHECK_EN.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;

    logic        req_valid, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        v0, w0;
    logic [31:0] a0, d0;
    logic        ready0, valid0, err0;
    logic [31:0] rdata0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    data_mem_responder u_dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    data_mem_responder #(.DEPTH(16), .WAIT_CYCLES(0)) u_dut0 (
        .clk       (clk),
        .reset     (reset),
        .req_valid (v0),
        .req_ready (ready0),
        .req_write (w0),
        .req_addr  (a0),
        .req_wdata (d0),
        .rsp_valid (valid0),
        .rsp_rdata (rdata0),
        .rsp_err   (err0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // One complete access on u_dut. The request is driven at a negedge and
    // accepted on the next rising edge. Latency is counted in negedges
    // after the accept edge, up to a bound of 20.
    task automatic access(input string tag, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd,
                          output logic er, output int lat);
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, "_busy"}, {31'd0, req_ready}, 32'd0);
        lat = 0;
        rd  = '0;
        er  = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (rsp_valid === 1'b1) begin
                lat = i;
                rd  = rsp_rdata;
                er  = rsp_err;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_lat"}, lat, 32'd3);
        @(negedge clk);
        check({tag, "_pulse"}, {31'd0, rsp_valid}, 32'd0);
        $display("access %s w=%0d addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0d lat=%0d",
                 tag, w, a, d, rd, er, lat);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] exp_rd [5];
    logic        op_w   [5];
    logic [31:0] op_a   [5];
    logic [31:0] op_d   [5];

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        v0 = 1'b0; w0 = 1'b0; a0 = '0; d0 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err",   {31'd0, rsp_err},   32'd0);
        check("rst0_ready", {31'd0, ready0}, 32'd1);
        reset = 1'b0;
        @(negedge clk);

        // Store, then load back.
        access("st10", 1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
        check("st10_rdata", rd, 32'd0);
        check("st10_err", {31'd0, er}, 32'd0);
        access("ld10", 1'b0, 32'h10, 32'd0, rd, er, lat);
        check("ld10_rdata", rd, 32'hDEADBEEF);

        // Wrap-around: 0x400 aliases word 0 when DEPTH is 256.
        access("st400", 1'b1, 32'h400, 32'h12345678, rd, er, lat);
        access("ld000", 1'b0, 32'h000, 32'd0, rd, er, lat);
        check("ld000_rdata", rd, 32'h12345678);

        // A reset in the first WAIT cycle aborts the store.
        access("st20", 1'b1, 32'h20, 32'h11112222, rd, er, lat);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hAAAA5555;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_in_wait", {31'd0, req_ready}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        check("abort_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort_rdata", rsp_rdata, 32'd0);
        check("abort_err",   {31'd0, rsp_err},   32'd0);
        reset = 1'b0;
        @(negedge clk);
        $display("reset abort of store 0xAAAA5555 to 0x20 applied");
        access("ld20", 1'b0, 32'h20, 32'd0, rd, er, lat);
        check("ld20_rdata", rd, 32'h11112222);

        // Misaligned store to 0x22.
        access("st22", 1'b1, 32'h22, 32'h1, rd, er, lat);
`ifdef ALIGN_CHECK_EN
        check("st22_err", {31'd0, er}, 32'd1);
        check("st22_rdata", rd, 32'd0);
        access("ld20b", 1'b0, 32'h20, 32'd0, rd, er, lat);
        check("ld20b_rdata", rd, 32'h11112222);
        check("ld20b_err", {31'd0, er}, 32'd0);
`else
        check("st22_err", {31'd0, er}, 32'd0);
        access("ld20b", 1'b0, 32'h20, 32'd0, rd, er, lat);
        check("ld20b_rdata", rd, 32'h00000001);
`endif

        // WAIT_CYCLES=0 instance with req_valid held high throughout.
        op_w[0] = 1'b1; op_a[0] = 32'h08; op_d[0] = 32'hCAFEF00D; exp_rd[0] = 32'd0;
        op_w[1] = 1'b1; op_a[1] = 32'h0C; op_d[1] = 32'h0BADF00D; exp_rd[1] = 32'd0;
        op_w[2] = 1'b0; op_a[2] = 32'h08; op_d[2] = 32'd0;        exp_rd[2] = 32'hCAFEF00D;
        op_w[3] = 1'b0; op_a[3] = 32'h0C; op_d[3] = 32'd0;        exp_rd[3] = 32'h0BADF00D;
        op_w[4] = 1'b0; op_a[4] = 32'h48; op_d[4] = 32'd0;        exp_rd[4] = 32'hCAFEF00D;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("w0_idle_ready%0d", i), {31'd0, ready0}, 32'd1);
            check($sformatf("w0_idle_valid%0d", i), {31'd0, valid0}, 32'd0);
            v0 = 1'b1; w0 = op_w[i]; a0 = op_a[i]; d0 = op_d[i];
            @(posedge clk);
            @(negedge clk);
            check($sformatf("w0_resp_valid%0d", i), {31'd0, valid0}, 32'd1);
            check($sformatf("w0_resp_ready%0d", i), {31'd0, ready0}, 32'd0);
            check($sformatf("w0_resp_rdata%0d", i), rdata0, exp_rd[i]);
            $display("w0 access %0d w=%0d addr=0x%08h wdata=0x%08h -> rdata=0x%08h",
                     i, op_w[i], op_a[i], op_d[i], rdata0);
            @(posedge clk);
            @(negedge clk);
        end
        v0 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
